// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM user-port arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      SD_IDLE  = 2'd0,
      SD_WRITE = 2'd1,
      SD_READ  = 2'd2
   } sd_cmd_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner select: optional fixed port-0 priority, else
// round-robin starting after the last winner.
module rr_priority_picker #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          prio0_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      j     = '0;
      any_o = |req_i;
      if (prio0_i && req_i[0]) begin
         gnt_o[0] = 1'b1;
      end else begin
         // walk downwards so the port nearest ptr+1 is written last and wins
         for (int i = N; i >= 1; i--) begin
            j = IW'((int'(ptr_i) + i) % N);
            if (req_i[j]) begin
               gnt_o    = '0;
               gnt_o[j] = 1'b1;
               idx_o    = j;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-requester front end for one sdram_controller user port.
// Optional watchdog: define SDRAM_ARB_WATCHDOG_EN.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 16,
   parameter int BURST_LEN  = 1,
   parameter int PORT0_PRIO = 1,
   parameter int TIMEOUT    = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0][1:0]        p_cmd,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] p_addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0] p_wdata,
   output logic [NUM_PORTS-1:0]             p_grant,
   output logic [NUM_PORTS-1:0]             p_wnext,
   output logic [NUM_PORTS-1:0]             p_rvalid,
   output logic [DATA_W-1:0]                p_rdata,
   output logic [NUM_PORTS-1:0]             p_done,
   output logic [1:0]                       sd_command,
   output logic [ADDR_W-1:0]                sd_address,
   output logic [DATA_W-1:0]                sd_wdata,
   input  logic [DATA_W-1:0]                sd_rdata,
   input  logic                             sd_rvalid,
   input  logic                             sd_wdone,
   output logic                             arb_err
);

   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BW = $clog2(BURST_LEN + 1);

   arb_state_e           state_q, state_d;
   logic [1:0]           cmd_q, cmd_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [NUM_PORTS-1:0] done_q, done_d;
   logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic [IW-1:0]        rr_q, rr_d;
   logic [BW-1:0]        beats_q, beats_d;

   logic [NUM_PORTS-1:0] req, win_oh;
   logic [IW-1:0]        win_idx;
   logic                 win_any, busy, rd_beat, wr_beat, last, tmo;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) req[i] = |p_cmd[i];
   end

   rr_priority_picker #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (rr_q),
      .prio0_i (PORT0_PRIO != 0),
      .gnt_o   (win_oh),
      .idx_o   (win_idx),
      .any_o   (win_any)
   );

   // rr_q doubles as the owner index while busy
   assign busy    = state_q == ARB_BUSY;
   assign rd_beat = busy && cmd_q == SD_READ && sd_rvalid;
   assign wr_beat = busy && cmd_q == SD_WRITE && sd_wdone;
   assign last    = (rd_beat || wr_beat) && beats_q == BW'(BURST_LEN - 1);

   assign sd_command = cmd_q;
   assign sd_address = addr_q;
   assign sd_wdata   = p_wdata[rr_q];
   assign p_grant    = grant_q;
   assign p_done     = done_q;
   assign p_rvalid   = rvalid_q;
   assign p_rdata    = rdata_q;
   assign p_wnext    = wr_beat ? grant_q : '0;

`ifdef SDRAM_ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wdog_q;
   logic          err_q;

   assign tmo     = busy && wdog_q == WW'(TIMEOUT - 1);
   assign arb_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= busy ? wdog_q + 1'b1 : '0;
         if (tmo) err_q <= 1'b1;
      end
   end
`else
   assign tmo     = 1'b0;
   assign arb_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      beats_d  = beats_q;
      rdata_d  = rdata_q;
      done_d   = '0;
      rvalid_d = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (win_any) begin
               cmd_d   = p_cmd[win_idx];
               addr_d  = p_addr[win_idx];
               grant_d = win_oh;
               rr_d    = win_idx;
               beats_d = '0;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (rd_beat) begin
               rvalid_d = grant_q;
               rdata_d  = sd_rdata;
            end
            if ((rd_beat || wr_beat) && beats_q != BW'(BURST_LEN))
               beats_d = beats_q + 1'b1;
            // drop the command on the final edge so the controller
            // never re-samples it when it returns to idle
            if (last || tmo) begin
               cmd_d   = SD_IDLE;
               grant_d = '0;
               done_d  = grant_q;
               state_d = ARB_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         cmd_q    <= SD_IDLE;
         addr_q   <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         rr_q     <= '0;
         beats_q  <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rr_q     <= rr_d;
         beats_q  <= beats_d;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: dut_a BURST_LEN=1 round-robin, dut_b BURST_LEN=4 port-0 priority.
// Small controller models answer each granted command on the falling edge.
module tb_sdram_port_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][1:0]  cmd_a = '0, cmd_b = '0;
   logic [1:0][23:0] addr_a = '0, addr_b = '0;
   logic [1:0][15:0] wd_a = '0, wd_b = '0;
   logic [1:0]       gnt_a, gnt_b, wn_a, wn_b, rv_a, rv_b, pd_a, pd_b;
   logic [15:0]      prd_a, prd_b, sdw_a, sdw_b;
   logic [15:0]      srd_a = '0, srd_b = '0;
   logic [1:0]       sdc_a, sdc_b;
   logic [23:0]      sda_a, sda_b;
   logic             srv_a = 0, swd_a = 0, srv_b = 0, swd_b = 0;
   logic             err_a, err_b;

   sdram_port_arbiter #(
      .NUM_PORTS(2), .ADDR_W(24), .DATA_W(16), .BURST_LEN(1),
      .PORT0_PRIO(0), .TIMEOUT(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .p_cmd(cmd_a), .p_addr(addr_a),
      .p_wdata(wd_a), .p_grant(gnt_a), .p_wnext(wn_a), .p_rvalid(rv_a),
      .p_rdata(prd_a), .p_done(pd_a), .sd_command(sdc_a),
      .sd_address(sda_a), .sd_wdata(sdw_a), .sd_rdata(srd_a),
      .sd_rvalid(srv_a), .sd_wdone(swd_a), .arb_err(err_a)
   );

   sdram_port_arbiter #(
      .NUM_PORTS(2), .ADDR_W(24), .DATA_W(16), .BURST_LEN(4),
      .PORT0_PRIO(1), .TIMEOUT(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .p_cmd(cmd_b), .p_addr(addr_b),
      .p_wdata(wd_b), .p_grant(gnt_b), .p_wnext(wn_b), .p_rvalid(rv_b),
      .p_rdata(prd_b), .p_done(pd_b), .sd_command(sdc_b),
      .sd_address(sda_b), .sd_wdata(sdw_b), .sd_rdata(srd_b),
      .sd_rvalid(srv_b), .sd_wdone(swd_b), .arb_err(err_b)
   );

   int n = 0, nf = 0;

   // controller models
   bit       mb_a = 0, mb_b = 0, mute_a = 0;
   int       ml_a = 0, ml_b = 0, gv_b = 0, lim_b = 99;
   logic [1:0] mc_a = '0, mc_b = '0;
   logic [15:0] cap_a[$], cap_b[$];

   always @(negedge clk) begin
      srv_a = 1'b0;
      swd_a = 1'b0;
      if (!rst_n) mb_a = 0;
      else if (mb_a) begin
         if (ml_a == 0) mb_a = 0;
         else begin
            if (mc_a == 2'd2) begin srv_a = 1'b1; srd_a = 16'hBEEF; end
            else swd_a = 1'b1;
            ml_a--;
         end
      end else if (sdc_a != 2'd0 && !mute_a) begin
         mb_a = 1; ml_a = 1; mc_a = sdc_a;
      end
   end

   always @(negedge clk) begin
      if (wn_b[1]) wd_b[1] = wd_b[1] + 16'd1;
      srv_b = 1'b0;
      swd_b = 1'b0;
      if (!rst_n) mb_b = 0;
      else if (mb_b) begin
         if (ml_b == 0) mb_b = 0;
         else if (gv_b < lim_b) begin
            if (mc_b == 2'd2) begin srv_b = 1'b1; srd_b = 16'hA000 + 16'(gv_b); end
            else swd_b = 1'b1;
            gv_b++;
            ml_b--;
         end
      end else if (sdc_b != 2'd0) begin
         mb_b = 1; ml_b = 4; gv_b = 0; mc_b = sdc_b;
      end
   end

   always @(posedge clk) begin
      if (swd_a) cap_a.push_back(sdw_a);
      if (swd_b) cap_b.push_back(sdw_b);
   end

   // monitors
   int glog_a[$], glog_b[$];
   int gapv_a = 0, gapv_b = 0, dn_a = 0, dn_b = 0, rvc_a = 0, rvc_b = 0;
   logic [1:0]  pg_a = '0, pg_b = '0;
   logic [15:0] lrd_a = '0, lrd_b = '0;

   function automatic int oh2i(input logic [1:0] v);
      return v[1] ? 1 : 0;
   endfunction

   always @(negedge clk) begin
      if (gnt_a != pg_a && gnt_a != 2'b00) begin
         glog_a.push_back(oh2i(gnt_a));
         if (pg_a != 2'b00) gapv_a++;
      end
      if (gnt_a == 2'b00 && sdc_a != 2'd0) gapv_a++;
      if (pd_a != 2'b00) dn_a++;
      if (rv_a != 2'b00) begin rvc_a++; lrd_a = prd_a; end
      pg_a = gnt_a;
      if (gnt_b != pg_b && gnt_b != 2'b00) begin
         glog_b.push_back(oh2i(gnt_b));
         if (pg_b != 2'b00) gapv_b++;
      end
      if (gnt_b == 2'b00 && sdc_b != 2'd0) gapv_b++;
      if (pd_b != 2'b00) dn_b++;
      if (rv_b != 2'b00) begin rvc_b++; lrd_b = prd_b; end
      pg_b = gnt_b;
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_a(input logic [1:0] m, output bit ok, output int cyc);
      ok = 0;
      for (cyc = 1; cyc <= 60; cyc++) begin
         tick();
         if ((pd_a & m) != 2'b00) begin ok = 1; return; end
      end
   endtask

   task automatic wait_b(input logic [1:0] m, output bit ok, output int cyc);
      ok = 0;
      for (cyc = 1; cyc <= 60; cyc++) begin
         tick();
         if ((pd_b & m) != 2'b00) begin ok = 1; return; end
      end
   endtask

   task automatic test_reset;
      n++;
      if ({sdc_a, sda_a, gnt_a, wn_a, rv_a, prd_a, pd_a, err_a} !== '0) begin
         nf++; $display("FAIL reset_a: got %h required 0",
            {sdc_a, sda_a, gnt_a, wn_a, rv_a, prd_a, pd_a, err_a});
      end
      n++;
      if ({sdc_b, sda_b, gnt_b, wn_b, rv_b, prd_b, pd_b, err_b} !== '0) begin
         nf++; $display("FAIL reset_b: got %h required 0",
            {sdc_b, sda_b, gnt_b, wn_b, rv_b, prd_b, pd_b, err_b});
      end
      rst_n = 1'b1;
      repeat (3) tick();
      n++;
      if ({sdc_a, gnt_a, sdc_b, gnt_b} !== '0) begin
         nf++; $display("FAIL idle_after_reset: got %h required 0",
            {sdc_a, gnt_a, sdc_b, gnt_b});
      end
   endtask

   task automatic test_single_read;
      bit ok;
      int cyc;
      rvc_a = 0;
      cmd_a[0] = 2'd2;
      addr_a[0] = 24'h000123;
      tick();
      n++;
      if ({sdc_a, sda_a, gnt_a} !== {2'd2, 24'h000123, 2'b01}) begin
         nf++; $display("FAIL rd_grant: got cmd %0d addr %h gnt %b required 2 000123 01",
            sdc_a, sda_a, gnt_a);
      end
      wait_a(2'b01, ok, cyc);
      n++;
      if (!ok || cyc != 2) begin
         nf++; $display("FAIL rd_done_latency: got ok %0d cyc %0d required 1 2", ok, cyc);
      end
      n++;
      if ({rv_a, prd_a, sdc_a, gnt_a} !== {2'b01, 16'hBEEF, 2'd0, 2'b00}) begin
         nf++; $display("FAIL rd_final_edge: got rv %b data %h cmd %0d gnt %b required 01 beef 0 00",
            rv_a, prd_a, sdc_a, gnt_a);
      end
      cmd_a[0] = 2'd0;
      repeat (3) tick();
      n++;
      if (rvc_a != 1) begin
         nf++; $display("FAIL rd_beat_count: got %0d required 1", rvc_a);
      end
   endtask

   task automatic test_single_write;
      bit ok;
      int cyc;
      cap_a.delete();
      cmd_a[1] = 2'd1;
      addr_a[1] = 24'h000777;
      wd_a[1] = 16'h5A5A;
      tick();
      n++;
      if ({sdc_a, gnt_a} !== {2'd1, 2'b10}) begin
         nf++; $display("FAIL wr1_grant: got cmd %0d gnt %b required 1 10", sdc_a, gnt_a);
      end
      wait_a(2'b10, ok, cyc);
      cmd_a[1] = 2'd0;
      repeat (3) tick();
      n++;
      if (!ok || cap_a.size() != 1 || cap_a[0] !== 16'h5A5A) begin
         nf++; $display("FAIL wr1_data: got ok %0d n %0d required 1 1 (5a5a)", ok, cap_a.size());
      end
   endtask

   task automatic test_round_robin;
      int got;
      glog_a.delete();
      gapv_a = 0;
      dn_a = 0;
      cmd_a[0] = 2'd2;
      cmd_a[1] = 2'd2;
      for (int i = 0; i < 80 && glog_a.size() < 4; i++) tick();
      cmd_a = '0;
      repeat (8) tick();
      got = -1;
      if (glog_a.size() == 4)
         got = glog_a[0] * 1000 + glog_a[1] * 100 + glog_a[2] * 10 + glog_a[3];
      n++;
      if (got != 101) begin
         nf++; $display("FAIL rr_order: got %0d required 0101", got);
      end
      n++;
      if (gapv_a != 0 || dn_a != 4) begin
         nf++; $display("FAIL rr_gaps: got gapv %0d done %0d required 0 4", gapv_a, dn_a);
      end
   endtask

   task automatic test_port0_prio;
      int got;
      glog_b.delete();
      gapv_b = 0;
      cmd_b[0] = 2'd2;
      cmd_b[1] = 2'd2;
      for (int i = 0; i < 80 && glog_b.size() < 3; i++) tick();
      cmd_b[0] = 2'd0;
      for (int i = 0; i < 80 && glog_b.size() < 4; i++) tick();
      cmd_b[1] = 2'd0;
      repeat (12) tick();
      got = -1;
      if (glog_b.size() == 4)
         got = glog_b[0] * 1000 + glog_b[1] * 100 + glog_b[2] * 10 + glog_b[3];
      n++;
      if (got != 1) begin
         nf++; $display("FAIL prio_order: got %0d required 0001", got);
      end
      n++;
      if (gapv_b != 0) begin
         nf++; $display("FAIL prio_gaps: got %0d required 0", gapv_b);
      end
   endtask

   task automatic test_write_burst;
      bit ok;
      int cyc;
      cap_b.delete();
      dn_b = 0;
      wd_b[1] = 16'd1;
      addr_b[1] = 24'h000800;
      cmd_b[1] = 2'd1;
      tick();
      n++;
      if ({sdc_b, sda_b, gnt_b} !== {2'd1, 24'h000800, 2'b10}) begin
         nf++; $display("FAIL wb_grant: got cmd %0d addr %h gnt %b required 1 000800 10",
            sdc_b, sda_b, gnt_b);
      end
      wait_b(2'b10, ok, cyc);
      cmd_b[1] = 2'd0;
      n++;
      if (!ok || cyc != 5) begin
         nf++; $display("FAIL wb_latency: got ok %0d cyc %0d required 1 5", ok, cyc);
      end
      repeat (6) tick();
      n++;
      if (cap_b.size() != 4 || cap_b[0] !== 16'd1 || cap_b[1] !== 16'd2 ||
          cap_b[2] !== 16'd3 || cap_b[3] !== 16'd4) begin
         nf++; $display("FAIL wb_data: got %0d beats required 1,2,3,4", cap_b.size());
      end
      n++;
      if (dn_b != 1) begin
         nf++; $display("FAIL wb_done_count: got %0d required 1", dn_b);
      end
   endtask

   task automatic test_reset_mid_burst;
      bit ok;
      int cyc;
      rvc_b = 0;
      lim_b = 2;
      addr_b[0] = 24'h000400;
      cmd_b[0] = 2'd2;
      for (int i = 0; i < 40 && rvc_b < 2; i++) tick();
      repeat (2) tick();
      n++;
      if (rvc_b != 2 || gnt_b !== 2'b01) begin
         nf++; $display("FAIL rm_stall: got beats %0d gnt %b required 2 01", rvc_b, gnt_b);
      end
      rst_n = 1'b0;
      #1;
      n++;
      if ({sdc_b, sda_b, gnt_b, wn_b, rv_b, prd_b, pd_b, sda_a} !== '0) begin
         nf++; $display("FAIL rm_async_reset: got %h required 0",
            {sdc_b, sda_b, gnt_b, wn_b, rv_b, prd_b, pd_b, sda_a});
      end
      cmd_b[0] = 2'd0;
      lim_b = 99;
      tick();
      rst_n = 1'b1;
      tick();
      rvc_b = 0;
      addr_b[1] = 24'h000042;
      cmd_b[1] = 2'd2;
      tick();
      n++;
      if ({sdc_b, sda_b, gnt_b} !== {2'd2, 24'h000042, 2'b10}) begin
         nf++; $display("FAIL rm_regrant: got cmd %0d addr %h gnt %b required 2 000042 10",
            sdc_b, sda_b, gnt_b);
      end
      wait_b(2'b10, ok, cyc);
      cmd_b[1] = 2'd0;
      tick();
      n++;
      if (!ok || rvc_b != 4 || lrd_b !== 16'hA003) begin
         nf++; $display("FAIL rm_clean_burst: got ok %0d beats %0d last %h required 1 4 a003",
            ok, rvc_b, lrd_b);
      end
   endtask

   task automatic test_watchdog;
`ifdef SDRAM_ARB_WATCHDOG_EN
      bit ok;
      int cyc;
      int cnt;
      mute_a = 1;
      cmd_a[0] = 2'd2;
      tick();
      n++;
      if (gnt_a !== 2'b01 || err_a !== 1'b0) begin
         nf++; $display("FAIL wd_grant: got gnt %b err %b required 01 0", gnt_a, err_a);
      end
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cnt++;
         if (pd_a[0]) break;
      end
      n++;
      if (cnt != 16 || err_a !== 1'b1 || sdc_a !== 2'd0) begin
         nf++; $display("FAIL wd_timeout: got clks %0d err %b cmd %0d required 16 1 0",
            cnt, err_a, sdc_a);
      end
      cmd_a[0] = 2'd0;
      cmd_a[1] = 2'd2;
      mute_a = 0;
      tick();
      n++;
      if (gnt_a !== 2'b10) begin
         nf++; $display("FAIL wd_next_grant: got %b required 10", gnt_a);
      end
      wait_a(2'b10, ok, cyc);
      cmd_a[1] = 2'd0;
      tick();
      n++;
      if (!ok || err_a !== 1'b1) begin
         nf++; $display("FAIL wd_sticky: got ok %0d err %b required 1 1", ok, err_a);
      end
`else
      n++;
      if ({err_a, err_b} !== 2'b00) begin
         nf++; $display("FAIL err_tied: got %b required 00", {err_a, err_b});
      end
`endif
   endtask

   initial begin
      repeat (3) tick();
      test_reset();
      test_single_read();
      test_single_write();
      test_round_robin();
      test_port0_prio();
      test_write_burst();
      test_reset_mid_burst();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, nf);
      $finish;
   end

endmodule
